// File: rtl/cpu_pkg.sv
// Shared definitions for the instruction fetch stage and the control decoder.
// Contents: the fetch FSM state encoding, the default reset PC, and the
// instruction field bit positions.
package cpu_pkg;

    typedef enum logic [1:0] {
        START = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } fetch_state_t;

    // MIPS text segment base
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;

    localparam int OPCODE_HI = 31;
    localparam int OPCODE_LO = 26;
    localparam int FUNCT_HI  = 5;
    localparam int FUNCT_LO  = 0;

endpackage

// File: rtl/instr_fetch_if.sv
// Instruction memory read bus.
//   imem_req   : read request, held with a stable address until imem_ack
//   imem_addr  : word address of the request (bits [1:0] are always 0)
//   imem_ack   : read data valid this cycle
//   imem_rdata : instruction word, valid when imem_ack = 1
// master = fetch stage, slave = instruction memory.
interface instr_fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/instr_fetch_pc_next.sv
// Next-PC computation for the fetch stage (purely combinational).
//   pc            : address of the held instruction
//   branch_taken  : held instruction is a taken branch
//   branch_target : target PC of the branch
//   next_pc       : word-aligned branch target, or pc + 4
//   pc_plus4      : pc + 4, wrapping modulo 2^32
//   misaligned    : taken branch whose target has nonzero low bits
module pc_next (
    input  logic [31:0] pc,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] next_pc,
    output logic [31:0] pc_plus4,
    output logic        misaligned
);

    assign pc_plus4   = pc + 32'd4;
    // The low bits are dropped rather than trapping; misaligned flags it.
    assign next_pc    = branch_taken ? {branch_target[31:2], 2'b00} : pc_plus4;
    assign misaligned = branch_taken && (branch_target[1:0] != 2'b00);

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: holds the PC, reads one word per instruction from
// instruction memory over a req/ack handshake, holds it in an instruction
// register for the decoder, and advances the PC when the datapath consumes it.
//
// Ports:
//   clock, reset   : rising-edge clock, synchronous active-high reset
//   imem           : instruction memory bus (master side)
//   stall          : datapath cannot consume the held instruction
//   branch_taken   : held instruction is a taken branch (sampled on consume)
//   branch_target  : branch target PC (sampled on consume)
//   instr          : held instruction register
//   instr_valid    : instr / pc / opcode / funct are valid
//   opcode, funct  : field slices of instr
//   pc, pc_plus4   : address of held instruction and its successor
//   instr_count    : instructions consumed since reset (wraps)
//   align_err      : sticky, a taken branch target had nonzero low bits
//
// state | meaning
// ------+-------------------------------------------------------------
// START | one idle cycle after reset; drops any ack from a stale request
// FETCH | request outstanding at pc, waiting for imem_ack
// HOLD  | instruction held for the decoder until the datapath consumes it
module instr_fetch
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          CNT_W    = 32
) (
    input  logic               clock,
    input  logic               reset,
    instr_fetch_if.master      imem,
    input  logic               stall,
    input  logic               branch_taken,
    input  logic [31:0]        branch_target,
    output logic [31:0]        instr,
    output logic               instr_valid,
    output logic [5:0]         opcode,
    output logic [5:0]         funct,
    output logic [31:0]        pc,
    output logic [31:0]        pc_plus4,
    output logic [CNT_W-1:0]   instr_count,
    output logic               align_err
);

    fetch_state_t state, state_next;
    logic         req_c;
    logic         capture;
    logic         consume;
    logic [31:0]  next_pc;
    logic         misaligned;

    pc_next u_pc_next (
        .pc            (pc),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .next_pc       (next_pc),
        .pc_plus4      (pc_plus4),
        .misaligned    (misaligned)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= START;
        end else begin
            state <= state_next;
        end
    end

    // Acks outside FETCH are protocol violations and fall through untouched.
    always_comb begin
        state_next = state;
        req_c      = 1'b0;
        capture    = 1'b0;
        consume    = 1'b0;
        case (state)
            START: begin
                state_next = FETCH;
            end
            FETCH: begin
                req_c = 1'b1;
                if (imem.imem_ack) begin
                    capture    = 1'b1;
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (!stall) begin
                    consume    = 1'b1;
                    state_next = FETCH;
                end
            end
            default: begin
                state_next = START;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pc          <= RESET_PC;
            instr       <= 32'd0;
            instr_valid <= 1'b0;
            instr_count <= '0;
            align_err   <= 1'b0;
        end else begin
            if (capture) begin
                instr       <= imem.imem_rdata;
                instr_valid <= 1'b1;
            end
            if (consume) begin
                pc          <= next_pc;
                instr_valid <= 1'b0;
                instr_count <= instr_count + CNT_W'(1);
                if (misaligned) begin
                    align_err <= 1'b1;
                end
            end
        end
    end

    // The request is driven from state, so it drops the cycle after the ack
    // and is low on the cycle following any reset.
    assign imem.imem_req  = req_c;
    assign imem.imem_addr = pc;

    assign opcode = instr[OPCODE_HI:OPCODE_LO];
    assign funct  = instr[FUNCT_HI:FUNCT_LO];

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

    localparam logic [31:0] RST_PC = 32'h0040_0000;

    logic        clock = 1'b0;
    logic        reset;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] instr;
    logic        instr_valid;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] instr_count;
    logic        align_err;

    int total = 0;
    int bad   = 0;

    instr_fetch_if bus ();

    instr_fetch #(.RESET_PC(RST_PC), .CNT_W(32)) dut (
        .clock         (clock),
        .reset         (reset),
        .imem          (bus),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .instr         (instr),
        .instr_valid   (instr_valid),
        .opcode        (opcode),
        .funct         (funct),
        .pc            (pc),
        .pc_plus4      (pc_plus4),
        .instr_count   (instr_count),
        .align_err     (align_err)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Leaves the DUT in START, one cycle after the reset edge.
    task automatic do_reset();
        reset         = 1'b1;
        stall         = 1'b1;
        branch_taken  = 1'b0;
        branch_target = 32'd0;
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = 32'd0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (bus.imem_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%0b want=0", bus.imem_req); end
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b want=0", instr_valid); end
        total++; if (instr !== 32'd0) begin bad++; $display("FAIL reset_instr got=%h want=0", instr); end
        total++; if (pc !== RST_PC) begin bad++; $display("FAIL reset_pc got=%h want=%h", pc, RST_PC); end
        total++; if (instr_count !== 32'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", instr_count); end
        total++; if (align_err !== 1'b0) begin bad++; $display("FAIL reset_align got=%0b want=0", align_err); end
        tick();
        total++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== RST_PC) begin
            bad++; $display("FAIL first_req got req=%0b addr=%h want req=1 addr=%h", bus.imem_req, bus.imem_addr, RST_PC);
        end
    endtask

    // Ack in the very first FETCH cycle, consumed right away.
    task automatic test_min_latency();
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'h2008_0005;
        stall          = 1'b0;
        tick();
        bus.imem_ack = 1'b0;
        total++; if (instr_valid !== 1'b1 || instr !== 32'h2008_0005) begin
            bad++; $display("FAIL min_capture got valid=%0b instr=%h want valid=1 instr=20080005", instr_valid, instr);
        end
        total++; if (opcode !== 6'h08 || funct !== 6'h05) begin
            bad++; $display("FAIL min_fields got op=%h fn=%h want op=08 fn=05", opcode, funct);
        end
        total++; if (bus.imem_req !== 1'b0) begin bad++; $display("FAIL min_req_drop got=%0b want=0", bus.imem_req); end
        tick();
        total++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0040_0004) begin
            bad++; $display("FAIL min_next_addr got req=%0b addr=%h want req=1 addr=00400004", bus.imem_req, bus.imem_addr);
        end
        total++; if (instr_count !== 32'd1 || instr_valid !== 1'b0) begin
            bad++; $display("FAIL min_count got count=%0d valid=%0b want count=1 valid=0", instr_count, instr_valid);
        end
    endtask

    // Ack after three wait cycles, then a stalled HOLD ending in a taken branch.
    task automatic test_delayed_ack_stall();
        logic [31:0] data;
        logic [31:0] tgt;
        data = $urandom;
        do_reset();
        tick();
        for (int i = 0; i < 4; i++) begin
            total++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== RST_PC) begin
                bad++; $display("FAIL delay_req_stable cyc=%0d got req=%0b addr=%h want req=1 addr=%h", i, bus.imem_req, bus.imem_addr, RST_PC);
            end
            bus.imem_ack   = (i == 3);
            bus.imem_rdata = (i == 3) ? data : ~data;
            tick();
        end
        bus.imem_ack = 1'b0;
        total++; if (instr_valid !== 1'b1 || instr !== data) begin
            bad++; $display("FAIL delay_capture got valid=%0b instr=%h want valid=1 instr=%h", instr_valid, instr, data);
        end
        for (int i = 0; i < 5; i++) begin
            branch_taken  = 1'b1;
            branch_target = $urandom & 32'hFFFF_FFFC;
            bus.imem_ack   = (i == 2);
            bus.imem_rdata = ~data;
            tick();
            total++; if (instr !== data || pc !== RST_PC || instr_valid !== 1'b1 || instr_count !== 32'd0 || bus.imem_req !== 1'b0) begin
                bad++; $display("FAIL stall_hold cyc=%0d got instr=%h pc=%h valid=%0b count=%0d req=%0b want instr=%h pc=%h valid=1 count=0 req=0",
                                i, instr, pc, instr_valid, instr_count, bus.imem_req, data, RST_PC);
            end
        end
        bus.imem_ack  = 1'b0;
        tgt           = 32'h0040_0100;
        stall         = 1'b0;
        branch_taken  = 1'b1;
        branch_target = tgt;
        tick();
        branch_taken = 1'b0;
        stall        = 1'b1;
        total++; if (bus.imem_addr !== tgt || bus.imem_req !== 1'b1 || instr_count !== 32'd1) begin
            bad++; $display("FAIL branch_consume got addr=%h req=%0b count=%0d want addr=%h req=1 count=1", bus.imem_addr, bus.imem_req, instr_count, tgt);
        end
    endtask

    // Misaligned taken branch: low bits cleared, sticky flag until reset.
    task automatic test_misaligned();
        bus.imem_ack = 1'b1; bus.imem_rdata = $urandom;
        tick();
        bus.imem_ack = 1'b0;
        total++; if (align_err !== 1'b0) begin bad++; $display("FAIL align_pre got=%0b want=0", align_err); end
        stall = 1'b0; branch_taken = 1'b1; branch_target = 32'h0040_0102;
        tick();
        branch_taken = 1'b0;
        total++; if (bus.imem_addr !== 32'h0040_0100 || align_err !== 1'b1) begin
            bad++; $display("FAIL align_set got addr=%h err=%0b want addr=00400100 err=1", bus.imem_addr, align_err);
        end
        for (int i = 0; i < 2; i++) begin
            bus.imem_ack = 1'b1; bus.imem_rdata = $urandom;
            tick();
            bus.imem_ack = 1'b0;
            tick();
        end
        total++; if (bus.imem_addr !== 32'h0040_0108 || align_err !== 1'b1) begin
            bad++; $display("FAIL align_sticky got addr=%h err=%0b want addr=00400108 err=1", bus.imem_addr, align_err);
        end
        do_reset();
        total++; if (align_err !== 1'b0) begin bad++; $display("FAIL align_clear got=%0b want=0", align_err); end
    endtask

    // Reset mid-FETCH with a stale ack arriving in START.
    task automatic test_reset_mid_fetch();
        tick();
        stall = 1'b0; branch_taken = 1'b1; branch_target = 32'h0000_1230;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'hDEAD_BEEF;
        total++; if (bus.imem_req !== 1'b0) begin bad++; $display("FAIL rst_mid_req got=%0b want=0", bus.imem_req); end
        tick();
        bus.imem_ack = 1'b0;
        total++; if (instr_valid !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== RST_PC) begin
            bad++; $display("FAIL rst_mid_ignore got valid=%0b req=%0b addr=%h want valid=0 req=1 addr=%h", instr_valid, bus.imem_req, bus.imem_addr, RST_PC);
        end
        branch_taken = 1'b0;
        stall        = 1'b1;
    endtask

    // PC wrap at the top of the address space.
    task automatic test_wrap();
        bus.imem_ack = 1'b1; bus.imem_rdata = $urandom;
        tick();
        bus.imem_ack = 1'b0;
        stall = 1'b0; branch_taken = 1'b1; branch_target = 32'hFFFF_FFFC;
        tick();
        branch_taken = 1'b0; stall = 1'b1;
        bus.imem_ack = 1'b1; bus.imem_rdata = $urandom;
        tick();
        bus.imem_ack = 1'b0;
        total++; if (pc !== 32'hFFFF_FFFC || pc_plus4 !== 32'd0) begin
            bad++; $display("FAIL wrap_plus4 got pc=%h plus4=%h want pc=fffffffc plus4=0", pc, pc_plus4);
        end
        stall = 1'b0;
        tick();
        stall = 1'b1;
        total++; if (bus.imem_addr !== 32'd0 || align_err !== 1'b0) begin
            bad++; $display("FAIL wrap_addr got addr=%h err=%0b want addr=0 err=0", bus.imem_addr, align_err);
        end
    endtask

    // Random latencies, stalls, branches and stray acks against a model of
    // the architectural state: pc, retired count, sticky alignment flag.
    task automatic test_random();
        logic [31:0] m_pc;
        logic [31:0] m_cnt;
        logic        m_align;
        logic [31:0] data;
        int          lat;
        int          nst;
        logic        bt;
        logic [31:0] tgt;
        do_reset();
        tick();
        m_pc = RST_PC; m_cnt = 0; m_align = 0;
        for (int n = 0; n < 60; n++) begin
            lat  = $urandom_range(0, 3);
            data = $urandom;
            for (int w = 0; w < lat; w++) begin
                stall = $urandom_range(0, 1); branch_taken = 1'b1; branch_target = $urandom;
                bus.imem_ack = 1'b0;
                total++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== m_pc) begin
                    bad++; $display("FAIL rnd_wait n=%0d got req=%0b addr=%h want req=1 addr=%h", n, bus.imem_req, bus.imem_addr, m_pc);
                end
                tick();
            end
            total++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== m_pc) begin
                bad++; $display("FAIL rnd_addr n=%0d got req=%0b addr=%h want req=1 addr=%h", n, bus.imem_req, bus.imem_addr, m_pc);
            end
            bus.imem_ack = 1'b1; bus.imem_rdata = data;
            tick();
            nst = $urandom_range(0, 2);
            for (int s = 0; s < nst; s++) begin
                stall = 1'b1; branch_taken = $urandom_range(0, 1); branch_target = $urandom;
                bus.imem_ack = $urandom_range(0, 1); bus.imem_rdata = ~data;
                tick();
            end
            bus.imem_ack = 1'b0;
            total++; if (instr_valid !== 1'b1 || instr !== data || pc !== m_pc || opcode !== data[31:26] || funct !== data[5:0]) begin
                bad++; $display("FAIL rnd_hold n=%0d got valid=%0b instr=%h pc=%h want valid=1 instr=%h pc=%h", n, instr_valid, instr, pc, data, m_pc);
            end
            total++; if (pc_plus4 !== m_pc + 32'd4) begin
                bad++; $display("FAIL rnd_plus4 n=%0d got=%h want=%h", n, pc_plus4, m_pc + 32'd4);
            end
            bt  = $urandom_range(0, 1);
            tgt = $urandom;
            if ($urandom_range(0, 3) != 0) tgt[1:0] = 2'b00;
            stall = 1'b0; branch_taken = bt; branch_target = tgt;
            if (bt) begin
                if (tgt % 4 != 0) m_align = 1'b1;
                m_pc = tgt - (tgt % 4);
            end else begin
                m_pc = m_pc + 32'd4;
            end
            m_cnt = m_cnt + 1;
            tick();
            total++; if (instr_count !== m_cnt || align_err !== m_align || instr_valid !== 1'b0) begin
                bad++; $display("FAIL rnd_consume n=%0d got count=%0d err=%0b valid=%0b want count=%0d err=%0b valid=0",
                                n, instr_count, align_err, instr_valid, m_cnt, m_align);
            end
        end
        stall = 1'b1; branch_taken = 1'b0;
    endtask

    initial begin
        test_reset();
        test_min_latency();
        test_delayed_ack_stall();
        test_misaligned();
        test_reset_mid_fetch();
        test_wrap();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
